// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave port: register map, status bit positions, FSM states.
package spi_slave_pkg;

  localparam logic [2:0] ADDR_RX      = 3'd0;
  localparam logic [2:0] ADDR_TX      = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  // Status / control bit positions within the 16-bit register word
  localparam int BIT_ROE  = 3;
  localparam int BIT_TOE  = 4;
  localparam int BIT_TMT  = 5;
  localparam int BIT_TRDY = 6;
  localparam int BIT_RRDY = 7;
  localparam int BIT_TUR  = 8;
  localparam int BIT_E    = 9;
  localparam int FLAG_LSB = 3;
  localparam int FLAG_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes SCLK/MOSI/SS_n into clk and produces single-cycle edge pulses.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_in,
  input  logic mosi_in,
  input  logic ss_n_in,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise
);

  localparam int LINES = 3;

  logic [LINES-1:0] line_in;
  logic [LINES-1:0] line_s;
  logic             sclk_prev_reg;
  logic             ss_prev_reg;

  assign line_in = {ss_n_in, mosi_in, sclk_in};

  // Chains reset to 0: a select held low through reset then shows no
  // falling edge, so a frame only starts on a genuinely new ss_fall.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;

    // Per-line synchronizer chain
    always_ff @(posedge clk) begin
      if (reset) chain_reg <= '0;
      else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], line_in[gi]};
    end

    assign line_s[gi] = chain_reg[SYNC_STAGES-1];
  end

  // Edge register one stage behind the synchronized SCLK and SS_n
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_reg <= 1'b0;
      ss_prev_reg   <= 1'b0;
    end else begin
      sclk_prev_reg <= line_s[0];
      ss_prev_reg   <= line_s[2];
    end
  end

  assign mosi_s    = line_s[1];
  assign sclk_rise =  line_s[0] & ~sclk_prev_reg;
  assign sclk_fall = ~line_s[0] &  sclk_prev_reg;
  assign ss_fall   = ~line_s[2] &  ss_prev_reg;
  assign ss_rise   =  line_s[2] & ~ss_prev_reg;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with rx/tx holding registers, status flags and IRQ.
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int                  DATABITS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DATABITS-1:0] IDLE_FILL   = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  output logic [15:0] data_to_cpu,
  output logic        irq
);

  localparam int                CNT_W = $clog2(DATABITS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATABITS - 1);

  logic mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk_in   (SCLK),
    .mosi_in   (MOSI),
    .ss_n_in   (SS_n),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [DATABITS-1:0] rx_shift_reg, tx_shift_reg, rx_holding_reg, tx_holding_reg;
  logic                miso_reg, primed_reg;
  logic                roe_reg, toe_reg, tur_reg, trdy_reg, rrdy_reg;
  logic [FLAG_W-1:0]   ctrl_reg;
  logic                rd_prev_reg, wr_prev_reg;
  logic [15:0]         data_to_cpu_reg;
  logic                irq_reg;

  // Bus strobes act on their first cycle only
  logic rd_strobe, wr_strobe, rd_first, wr_first;
  logic rx_read, tx_write, stat_write, ctrl_write;
  assign rd_strobe  = spi_select & ~read_n;
  assign wr_strobe  = spi_select & ~write_n;
  assign rd_first   = rd_strobe & ~rd_prev_reg;
  assign wr_first   = wr_strobe & ~wr_prev_reg;
  assign rx_read    = rd_first & (mem_addr == ADDR_RX);
  assign tx_write   = wr_first & (mem_addr == ADDR_TX);
  assign stat_write = wr_first & (mem_addr == ADDR_STATUS);
  assign ctrl_write = wr_first & (mem_addr == ADDR_CONTROL);

  // Shift-side events; a select release overrides anything else that cycle
  logic                shifting, load_now, rise_now, byte_done, fall_shift;
  logic [DATABITS-1:0] rx_next, load_byte;
  assign shifting   = (state_reg == ST_SHIFT) & ~ss_rise;
  assign rise_now   = shifting & sclk_rise;
  assign byte_done  = rise_now & (bit_cnt_reg == LAST);
  assign load_now   = ((state_reg == ST_LOAD) & ~ss_rise) |
                      (shifting & sclk_fall & (bit_cnt_reg == '0));
  assign fall_shift = shifting & sclk_fall & (bit_cnt_reg != '0);
  assign rx_next    = {rx_shift_reg[DATABITS-2:0], mosi_s};
  assign load_byte  = primed_reg ? tx_holding_reg : IDLE_FILL;

  // Frame sequencing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (ss_fall) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: state_next = ST_SHIFT;
      default:  state_next = ST_IDLE;
    endcase
    if (ss_rise) state_next = ST_IDLE;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Bit counter, receive/transmit shifters and MISO
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg    <= '0;
      rx_shift_reg   <= '0;
      rx_holding_reg <= '0;
      tx_shift_reg   <= '0;
      miso_reg       <= 1'b0;
    end else begin
      if (ss_rise) begin
        bit_cnt_reg <= '0;
      end else if (rise_now) begin
        rx_shift_reg <= rx_next;
        bit_cnt_reg  <= byte_done ? '0 : bit_cnt_reg + 1'b1;
        if (byte_done) rx_holding_reg <= rx_next;
      end
      if (load_now) begin
        tx_shift_reg <= load_byte;
        miso_reg     <= load_byte[DATABITS-1];
        if (state_reg == ST_LOAD) bit_cnt_reg <= '0;
      end else if (fall_shift) begin
        tx_shift_reg <= {tx_shift_reg[DATABITS-2:0], 1'b0};
        miso_reg     <= tx_shift_reg[DATABITS-2];
      end
    end
  end

  // tx holding register and status flags; sets are ordered after clears so a set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_holding_reg <= '0;
      primed_reg     <= 1'b0;
      trdy_reg       <= 1'b0;
      rrdy_reg       <= 1'b0;
      roe_reg        <= 1'b0;
      toe_reg        <= 1'b0;
      tur_reg        <= 1'b0;
    end else begin
      if (load_now) begin
        primed_reg <= 1'b0;
        trdy_reg   <= 1'b1;
      end
      // Acceptance follows the holding register being empty, so the first
      // write after reset is taken even though TRDY reads 0 until a load.
      if (tx_write && !primed_reg) begin
        tx_holding_reg <= data_from_cpu[DATABITS-1:0];
        primed_reg     <= 1'b1;
        trdy_reg       <= 1'b0;
      end
      if (stat_write) begin
        roe_reg <= 1'b0;
        toe_reg <= 1'b0;
        tur_reg <= 1'b0;
      end
      if (load_now && !primed_reg) tur_reg <= 1'b1;
      if (tx_write && primed_reg)  toe_reg <= 1'b1;
      if (rx_read) rrdy_reg <= 1'b0;
      if (byte_done) begin
        rrdy_reg <= 1'b1;
        if (rrdy_reg && !rx_read) roe_reg <= 1'b1;
      end
    end
  end

  // Register-word views of status and control
  logic [15:0] status_word, ctrl_word, rd_mux;
  always_comb begin
    status_word           = '0;
    status_word[BIT_ROE]  = roe_reg;
    status_word[BIT_TOE]  = toe_reg;
    status_word[BIT_TMT]  = ~primed_reg & (state_reg == ST_IDLE);
    status_word[BIT_TRDY] = trdy_reg;
    status_word[BIT_RRDY] = rrdy_reg;
    status_word[BIT_TUR]  = tur_reg;
    status_word[BIT_E]    = roe_reg | toe_reg | tur_reg;
    ctrl_word             = '0;
    ctrl_word[FLAG_LSB +: FLAG_W] = ctrl_reg;
    case (mem_addr)
      ADDR_RX:      rd_mux = 16'(rx_holding_reg);
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_CONTROL: rd_mux = ctrl_word;
      default:      rd_mux = '0;
    endcase
  end

  // Bus edge tracking, control register, read data and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_prev_reg     <= 1'b0;
      wr_prev_reg     <= 1'b0;
      ctrl_reg        <= '0;
      data_to_cpu_reg <= '0;
      irq_reg         <= 1'b0;
    end else begin
      rd_prev_reg <= rd_strobe;
      wr_prev_reg <= wr_strobe;
      if (ctrl_write) ctrl_reg <= data_from_cpu[FLAG_LSB +: FLAG_W];
      if (rd_first)   data_to_cpu_reg <= rd_mux;
      irq_reg <= |(status_word[FLAG_LSB +: FLAG_W] & ctrl_reg);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{data_from_cpu[15:10], rx_shift_reg[DATABITS-1], tx_shift_reg[DATABITS-1]};

  assign MISO        = miso_reg;
  assign MISO_oe     = (state_reg != ST_IDLE);
  assign data_to_cpu = data_to_cpu_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench: drives SPI frames and bus accesses, checks against a transaction-level model.
module tb_spi_slave_port;

  localparam int HALF = 25;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset, SCLK, MOSI, SS_n, MISO, MISO_oe;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        spi_select, read_n, write_n, irq;

  always #5 clk = ~clk;

  spi_slave_port dut (
    .clk           (clk),
    .reset         (reset),
    .SCLK          (SCLK),
    .MOSI          (MOSI),
    .SS_n          (SS_n),
    .MISO          (MISO),
    .MISO_oe       (MISO_oe),
    .mem_addr      (mem_addr),
    .data_from_cpu (data_from_cpu),
    .spi_select    (spi_select),
    .read_n        (read_n),
    .write_n       (write_n),
    .data_to_cpu   (data_to_cpu),
    .irq           (irq)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model of the register file
  logic       m_primed, m_active;
  logic [7:0] m_hold, m_rx, m_txbyte;
  logic       m_roe, m_toe, m_tur, m_trdy, m_rrdy;
  logic [6:0] m_ctrl;
  bit         chk_en = 1'b0;

  task automatic model_reset();
    m_primed = 0; m_active = 0; m_hold = 0; m_rx = 0; m_txbyte = 0;
    m_roe = 0; m_toe = 0; m_tur = 0; m_trdy = 0; m_rrdy = 0; m_ctrl = 0;
  endtask

  // Start of a byte slot: holding byte (or fill) becomes the outgoing byte
  task automatic model_load();
    m_txbyte = m_primed ? m_hold : 8'h00;
    if (!m_primed) m_tur = 1;
    m_primed = 0;
    m_trdy   = 1;
    m_active = 1;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[3] = m_roe;
    s[4] = m_toe;
    s[5] = ~m_primed & ~m_active;
    s[6] = m_trdy;
    s[7] = m_rrdy;
    s[8] = m_tur;
    s[9] = m_roe | m_toe | m_tur;
    return s;
  endfunction

  function automatic logic exp_irq();
    logic [15:0] s;
    s = m_status();
    return |(s[9:3] & m_ctrl);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Continuous comparison of irq and MISO_oe while the design is quiescent
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq", {15'b0, irq}, {15'b0, exp_irq()});
      check("miso_oe", {15'b0, MISO_oe}, {15'b0, m_active});
    end
  end

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  task automatic bus_op(input bit wr, input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; mem_addr = a; data_from_cpu = d;
    if (wr) write_n = 1'b0; else read_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic cpu_tx(input logic [7:0] d);
    chk_en = 0;
    bus_op(1'b1, 3'd1, {8'h00, d});
    if (!m_primed) begin m_hold = d; m_primed = 1; m_trdy = 0; end
    else m_toe = 1;
    $display("txn tx_write data=%h", d);
    settle();
  endtask

  task automatic cpu_ctrl(input logic [15:0] d);
    chk_en = 0;
    bus_op(1'b1, 3'd3, d);
    m_ctrl = d[9:3];
    $display("txn ctrl_write data=%h", d);
    settle();
  endtask

  task automatic cpu_stat_clear();
    chk_en = 0;
    bus_op(1'b1, 3'd2, 16'($urandom));
    m_roe = 0; m_toe = 0; m_tur = 0;
    $display("txn status_write");
    settle();
  endtask

  task automatic cpu_rx(input string name);
    chk_en = 0;
    bus_op(1'b0, 3'd0, 16'h0);
    check(name, data_to_cpu, {8'h00, m_rx});
    m_rrdy = 0;
    $display("txn rx_read data=%h", data_to_cpu);
    settle();
  endtask

  task automatic cpu_status(input string name);
    chk_en = 0;
    bus_op(1'b0, 3'd2, 16'h0);
    check(name, data_to_cpu, m_status());
    $display("txn status_read data=%h", data_to_cpu);
    settle();
  endtask

  task automatic cpu_ctrl_read();
    chk_en = 0;
    bus_op(1'b0, 3'd3, 16'h0);
    check("ctrl_read", data_to_cpu, {6'b0, m_ctrl, 3'b0});
    $display("txn ctrl_read data=%h", data_to_cpu);
    settle();
  endtask

  // SPI master: nbits bits, optional select assert/release, optional rx read
  // landing on the same clk as the byte completion.
  task automatic frame(input logic [7:0] mosi_byte, input int nbits, input bit start,
                       input bit stop, input bit rd_race, output logic [7:0] miso_byte);
    chk_en = 0;
    miso_byte = '0;
    if (start) begin
      @(posedge clk); #1;
      SS_n = 1'b0;
      model_load();
    end
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_byte[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      miso_byte[7-i] = MISO;
      check("miso_bit", {15'b0, MISO}, {15'b0, m_txbyte[7-i]});
      SCLK = 1'b1;
      if (i == 7) begin
        if (rd_race) begin
          @(posedge clk);
          bus_op(1'b0, 3'd0, 16'h0);
          check("race_rd_data", data_to_cpu, {8'h00, m_rx});
          repeat (HALF-4) @(posedge clk);
          #1;
        end else begin
          if (m_rrdy) m_roe = 1;
          repeat (HALF) @(posedge clk);
          #1;
        end
        m_rx = mosi_byte;
        m_rrdy = 1;
      end else begin
        repeat (HALF) @(posedge clk);
        #1;
      end
      SCLK = 1'b0;
      if (i == 7) model_load();
    end
    if (stop) begin
      repeat (HALF) @(posedge clk);
      #1;
      SS_n = 1'b1;
      m_active = 0;
    end
    $display("txn frame mosi=%h bits=%0d miso=%h race=%0d", mosi_byte, nbits, miso_byte, rd_race);
    settle();
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    reset = 1; SCLK = 0; MOSI = 0; SS_n = 1;
    spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0; data_from_cpu = 0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("reset_miso", {15'b0, MISO}, 16'h0);
    check("reset_miso_oe", {15'b0, MISO_oe}, 16'h0);
    check("reset_data", data_to_cpu, 16'h0);
    check("reset_irq", {15'b0, irq}, 16'h0);
    reset = 0;
    settle();
    cpu_status("reset_status");
    check("reset_status_lit", data_to_cpu, 16'h0020);

    // Basic exchange with RRDY interrupt enabled
    cpu_ctrl(16'h0080);
    cpu_ctrl_read();
    cpu_tx(8'hA5);
    frame(8'h3C, 8, 1, 1, 0, got);
    check("t1_miso_byte", {8'h0, got}, 16'h00A5);
    cpu_status("t1_status");
    check("t1_status_lit", data_to_cpu, 16'h03E0);
    check("t1_irq_lit", {15'b0, irq}, 16'h0001);
    cpu_rx("t1_rx");
    check("t1_rx_lit", data_to_cpu, 16'h003C);

    // Back-to-back frames, no read between: overrun
    cpu_stat_clear();
    cpu_tx(8'h11);
    frame(8'h5E, 8, 1, 0, 0, got);
    frame(8'hC3, 8, 0, 1, 0, got);
    check("t2_fill_lit", {8'h0, got}, 16'h0000);
    cpu_status("t2_status");
    check("t2_status_lit", data_to_cpu, 16'h03E8);
    cpu_stat_clear();
    cpu_status("t2_cleared");
    check("t2_cleared_lit", data_to_cpu, 16'h00E0);
    cpu_rx("t2_rx");
    check("t2_rx_lit", data_to_cpu, 16'h00C3);

    // Underrun, then tx overrun with the second write dropped
    cpu_stat_clear();
    frame(8'h77, 8, 1, 1, 0, got);
    cpu_status("t3_tur");
    cpu_tx(8'h12);
    cpu_tx(8'h34);
    cpu_status("t3_toe");
    frame(8'h00, 8, 1, 1, 0, got);
    check("t3_kept_first_lit", {8'h0, got}, 16'h0012);

    // Aborted partial frame followed by a full one
    cpu_rx("t4_pre_rx");
    cpu_stat_clear();
    frame(8'hFF, 3, 1, 1, 0, got);
    cpu_status("t4_after_abort");
    frame(8'h81, 8, 1, 1, 0, got);
    cpu_status("t4_status");
    cpu_rx("t4_rx");
    check("t4_rx_lit", data_to_cpu, 16'h0081);

    // rx read coinciding with byte completion
    cpu_stat_clear();
    frame(8'h42, 8, 1, 1, 0, got);
    frame(8'h99, 8, 1, 1, 1, got);
    cpu_status("t5_status");
    check("t5_rrdy_roe_lit", data_to_cpu & 16'h0088, 16'h0080);
    cpu_rx("t5_rx");

    // Reset in the middle of a frame, select still low afterwards
    cpu_tx(8'h5A);
    frame(8'hF0, 3, 1, 0, 0, got);
    chk_en = 0;
    @(posedge clk); #1;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_miso", {15'b0, MISO}, 16'h0);
    check("t6_miso_oe", {15'b0, MISO_oe}, 16'h0);
    check("t6_data", data_to_cpu, 16'h0);
    check("t6_irq", {15'b0, irq}, 16'h0);
    model_reset();
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    chk_en = 1;
    cpu_status("t6_status");
    check("t6_status_lit", data_to_cpu, 16'h0020);
    chk_en = 0;
    @(posedge clk); #1;
    SS_n = 1'b1;
    settle();
    cpu_tx(8'h6B);
    frame(8'hD2, 8, 1, 1, 0, got);
    check("t6_miso_byte", {8'h0, got}, 16'h006B);
    cpu_rx("t6_rx");
    check("t6_rx_lit", data_to_cpu, 16'h00D2);

    // Randomized operation mix
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 5))
        0: cpu_tx(8'($urandom));
        1: cpu_rx("rnd_rx");
        2: cpu_stat_clear();
        3: cpu_ctrl(16'($urandom));
        4: frame(8'($urandom), 8, 1, 1, ($urandom_range(0, 3) == 0), got);
        default: frame(8'($urandom), $urandom_range(1, 7), 1, 1, 0, got);
      endcase
      cpu_status("rnd_status");
    end
    cpu_ctrl_read();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
